// File: rtl/my_reset_sequencer.sv
// Staged reset release for N_DOM reset domains: a minimum hold time, then PLL lock, then one
// domain per STEP_CYCLES. Lock loss, soft request or watchdog expiry restarts the sequence.
module my_reset_sequencer #(
    parameter int unsigned N_DOM       = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STEP_CYCLES = 256,
    parameter int unsigned WDOG_CYCLES = 0
) (
    input  logic             i_sys_clk,
    input  logic             i_sys_rst,
    input  logic             i_pll_locked,
    input  logic             i_soft_rst_req,
    input  logic             i_wdog_kick,
    output logic [N_DOM-1:0] o_dom_rst,
    output logic             o_system_ready,
    output logic [1:0]       o_rst_cause
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned WCNT_W  = $clog2(WDOG_CYCLES) + 1;
    localparam int unsigned IDX_W   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [WCNT_W-1:0] WDOG_LAST = WCNT_W'(WDOG_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DOM - 1);

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SOFT = 2'd2;
    localparam logic [1:0] CAUSE_WDOG = 2'd3;

    typedef enum logic [1:0] {
        StHold,
        StWaitLock,
        StRelease,
        StRun
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [N_DOM-1:0]    dom_rst_q, dom_rst_d;
    logic                ready_q, ready_d;
    logic [1:0]          cause_q, cause_d;
    logic                lock_meta_q, lock_s_q;
    logic                restart;
    logic [1:0]          restart_cause;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        wcnt_d        = '0;
        dom_rst_d     = dom_rst_q;
        cause_d       = cause_q;
        restart       = 1'b0;
        restart_cause = CAUSE_POR;

        unique case (state_q)
            StHold: begin
                dom_rst_d = {N_DOM{1'b1}};
                if (cnt_q == HOLD_LAST) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLock: begin
                if (lock_s_q) begin
                    state_d = StRelease;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                if (!lock_s_q) begin
                    restart       = 1'b1;
                    restart_cause = CAUSE_LOCK;
                end else if (cnt_q == STEP_LAST) begin
                    cnt_d = '0;
                    for (int i = 0; i < int'(N_DOM); i++) begin
                        if (IDX_W'(i) == idx_q) begin
                            dom_rst_d[i] = 1'b0;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = StRun;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!lock_s_q) begin
                    restart       = 1'b1;
                    restart_cause = CAUSE_LOCK;
                end else if (i_soft_rst_req) begin
                    restart       = 1'b1;
                    restart_cause = CAUSE_SOFT;
                end else if (WDOG_CYCLES != 0) begin
                    if (i_wdog_kick) begin
                        wcnt_d = '0;
                    end else if (wcnt_q == WDOG_LAST) begin
                        restart       = 1'b1;
                        restart_cause = CAUSE_WDOG;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
        endcase

        if (restart) begin
            state_d   = StHold;
            cnt_d     = '0;
            idx_d     = '0;
            wcnt_d    = '0;
            dom_rst_d = {N_DOM{1'b1}};
            cause_d   = restart_cause;
        end

        ready_d = (state_d == StRun);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            dom_rst_q   <= {N_DOM{1'b1}};
            ready_q     <= 1'b0;
            cause_q     <= CAUSE_POR;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            dom_rst_q   <= dom_rst_d;
            ready_q     <= ready_d;
            cause_q     <= cause_d;
            lock_meta_q <= i_pll_locked;
            lock_s_q    <= lock_meta_q;
        end
    end

    assign o_dom_rst      = dom_rst_q;
    assign o_system_ready = ready_q;
    assign o_rst_cause    = cause_q;

endmodule

// File: tb/tb_my_reset_sequencer.sv
// Directed bench for my_reset_sequencer: default instance for sequencing/restart scenarios,
// second instance with WDOG_CYCLES=1000 for watchdog behaviour.
module tb_my_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_lock, a_soft, a_kick;
    logic [2:0] a_dom;
    logic       a_rdy;
    logic [1:0] a_cause;

    logic       b_rst, b_lock, b_soft, b_kick;
    logic [2:0] b_dom;
    logic       b_rdy;
    logic [1:0] b_cause;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;

    typedef struct packed {
        logic [15:0] e;
        logic [2:0]  dom;
        logic        rdy;
        logic [1:0]  cause;
    } chk_t;

    my_reset_sequencer u_dut_a (
        .i_sys_clk      (clk),
        .i_sys_rst      (a_rst),
        .i_pll_locked   (a_lock),
        .i_soft_rst_req (a_soft),
        .i_wdog_kick    (a_kick),
        .o_dom_rst      (a_dom),
        .o_system_ready (a_rdy),
        .o_rst_cause    (a_cause)
    );

    my_reset_sequencer #(
        .WDOG_CYCLES (1000)
    ) u_dut_b (
        .i_sys_clk      (clk),
        .i_sys_rst      (b_rst),
        .i_pll_locked   (b_lock),
        .i_soft_rst_req (b_soft),
        .i_wdog_kick    (b_kick),
        .o_dom_rst      (b_dom),
        .o_system_ready (b_rdy),
        .o_rst_cause    (b_cause)
    );

    // Outputs are sampled 1ns after each rising edge; edge_cnt names the edge just taken.
    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    task automatic run_to(input int n);
        while (edge_cnt < n) step();
    endtask

    task automatic test_reset();
        a_rst = 1'b1; a_lock = 1'b1; a_soft = 1'b1; a_kick = 1'b0;
        step();
        a_soft = 1'b0;
        step();
        vectors++;
        if ({a_dom, a_rdy, a_cause} !== {3'b111, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL reset: got dom=%b rdy=%b cause=%0d want dom=111 rdy=0 cause=0",
                     a_dom, a_rdy, a_cause);
        end
        a_rst = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic test_por_sequence();
        chk_t v[9] = '{
            '{16'd1,   3'b111, 1'b0, 2'd0}, '{16'd16,  3'b111, 1'b0, 2'd0},
            '{16'd272, 3'b111, 1'b0, 2'd0}, '{16'd273, 3'b110, 1'b0, 2'd0},
            '{16'd528, 3'b110, 1'b0, 2'd0}, '{16'd529, 3'b100, 1'b0, 2'd0},
            '{16'd784, 3'b100, 1'b0, 2'd0}, '{16'd785, 3'b000, 1'b1, 2'd0},
            '{16'd800, 3'b000, 1'b1, 2'd0}};
        foreach (v[i]) begin
            run_to(int'(v[i].e));
            vectors++;
            if ({a_dom, a_rdy, a_cause} !== {v[i].dom, v[i].rdy, v[i].cause}) begin
                miscompares++;
                $display("FAIL por_seq@%0d: got dom=%b rdy=%b cause=%0d want dom=%b rdy=%b cause=%0d",
                         edge_cnt, a_dom, a_rdy, a_cause, v[i].dom, v[i].rdy, v[i].cause);
            end
        end
    endtask

    task automatic test_lock_loss();
        chk_t v[8] = '{
            '{16'd801,  3'b000, 1'b1, 2'd0}, '{16'd802,  3'b000, 1'b1, 2'd0},
            '{16'd803,  3'b111, 1'b0, 2'd1}, '{16'd1075, 3'b111, 1'b0, 2'd1},
            '{16'd1076, 3'b110, 1'b0, 2'd1}, '{16'd1332, 3'b100, 1'b0, 2'd1},
            '{16'd1587, 3'b100, 1'b0, 2'd1}, '{16'd1588, 3'b000, 1'b1, 2'd1}};
        run_to(800);
        a_lock = 1'b0;
        foreach (v[i]) begin
            run_to(int'(v[i].e));
            if (edge_cnt == 803) a_lock = 1'b1;
            vectors++;
            if ({a_dom, a_rdy, a_cause} !== {v[i].dom, v[i].rdy, v[i].cause}) begin
                miscompares++;
                $display("FAIL lock_loss@%0d: got dom=%b rdy=%b cause=%0d want dom=%b rdy=%b cause=%0d",
                         edge_cnt, a_dom, a_rdy, a_cause, v[i].dom, v[i].rdy, v[i].cause);
            end
        end
    endtask

    task automatic test_soft_pulse();
        chk_t v[5] = '{
            '{16'd1599, 3'b000, 1'b1, 2'd1}, '{16'd1600, 3'b111, 1'b0, 2'd2},
            '{16'd1700, 3'b111, 1'b0, 2'd2}, '{16'd1872, 3'b111, 1'b0, 2'd2},
            '{16'd1873, 3'b110, 1'b0, 2'd2}};
        foreach (v[i]) begin
            run_to(int'(v[i].e) - 1);
            // Pulse lands in RUN at 1600 and mid-RELEASE at 1700.
            if (v[i].e == 16'd1600 || v[i].e == 16'd1700) a_soft = 1'b1;
            step();
            a_soft = 1'b0;
            vectors++;
            if ({a_dom, a_rdy, a_cause} !== {v[i].dom, v[i].rdy, v[i].cause}) begin
                miscompares++;
                $display("FAIL soft_pulse@%0d: got dom=%b rdy=%b cause=%0d want dom=%b rdy=%b cause=%0d",
                         edge_cnt, a_dom, a_rdy, a_cause, v[i].dom, v[i].rdy, v[i].cause);
            end
        end
    endtask

    task automatic test_sys_rst_mid_release();
        chk_t v[3] = '{
            '{16'd1,   3'b111, 1'b0, 2'd0}, '{16'd272, 3'b111, 1'b0, 2'd0},
            '{16'd273, 3'b110, 1'b0, 2'd0}};
        run_to(1999);
        a_rst = 1'b1;
        step();
        vectors++;
        if ({a_dom, a_rdy, a_cause} !== {3'b111, 1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL sys_rst_mid: got dom=%b rdy=%b cause=%0d want dom=111 rdy=0 cause=0",
                     a_dom, a_rdy, a_cause);
        end
        a_rst = 1'b0;
        edge_cnt = 0;
        foreach (v[i]) begin
            run_to(int'(v[i].e));
            vectors++;
            if ({a_dom, a_rdy, a_cause} !== {v[i].dom, v[i].rdy, v[i].cause}) begin
                miscompares++;
                $display("FAIL sys_rst_restart@%0d: got dom=%b rdy=%b cause=%0d want dom=%b rdy=%b cause=%0d",
                         edge_cnt, a_dom, a_rdy, a_cause, v[i].dom, v[i].rdy, v[i].cause);
            end
        end
    endtask

    task automatic test_late_lock();
        chk_t v[8] = '{
            '{16'd99,  3'b111, 1'b0, 2'd0}, '{16'd101, 3'b111, 1'b0, 2'd0},
            '{16'd357, 3'b111, 1'b0, 2'd0}, '{16'd358, 3'b110, 1'b0, 2'd0},
            '{16'd613, 3'b110, 1'b0, 2'd0}, '{16'd614, 3'b100, 1'b0, 2'd0},
            '{16'd869, 3'b100, 1'b0, 2'd0}, '{16'd870, 3'b000, 1'b1, 2'd0}};
        a_rst = 1'b1; a_lock = 1'b0;
        step(); step();
        a_rst = 1'b0;
        edge_cnt = 0;
        foreach (v[i]) begin
            run_to(int'(v[i].e));
            if (edge_cnt == 99) a_lock = 1'b1;
            vectors++;
            if ({a_dom, a_rdy, a_cause} !== {v[i].dom, v[i].rdy, v[i].cause}) begin
                miscompares++;
                $display("FAIL late_lock@%0d: got dom=%b rdy=%b cause=%0d want dom=%b rdy=%b cause=%0d",
                         edge_cnt, a_dom, a_rdy, a_cause, v[i].dom, v[i].rdy, v[i].cause);
            end
        end
    endtask

    task automatic test_soft_held();
        chk_t v[6] = '{
            '{16'd881,  3'b111, 1'b0, 2'd2}, '{16'd1665, 3'b100, 1'b0, 2'd2},
            '{16'd1666, 3'b000, 1'b1, 2'd2}, '{16'd1667, 3'b111, 1'b0, 2'd2},
            '{16'd2452, 3'b000, 1'b1, 2'd2}, '{16'd2460, 3'b000, 1'b1, 2'd2}};
        run_to(880);
        a_soft = 1'b1;
        foreach (v[i]) begin
            run_to(int'(v[i].e));
            if (edge_cnt == 1667) a_soft = 1'b0;
            vectors++;
            if ({a_dom, a_rdy, a_cause} !== {v[i].dom, v[i].rdy, v[i].cause}) begin
                miscompares++;
                $display("FAIL soft_held@%0d: got dom=%b rdy=%b cause=%0d want dom=%b rdy=%b cause=%0d",
                         edge_cnt, a_dom, a_rdy, a_cause, v[i].dom, v[i].rdy, v[i].cause);
            end
        end
    endtask

    task automatic test_watchdog();
        chk_t v[6] = '{
            '{16'd784,  3'b100, 1'b0, 2'd0}, '{16'd785,  3'b000, 1'b1, 2'd0},
            '{16'd1784, 3'b000, 1'b1, 2'd0}, '{16'd1785, 3'b111, 1'b0, 2'd3},
            '{16'd2569, 3'b100, 1'b0, 2'd3}, '{16'd2570, 3'b000, 1'b1, 2'd3}};
        chk_t w[2] = '{
            '{16'd13569, 3'b000, 1'b1, 2'd3}, '{16'd13570, 3'b111, 1'b0, 2'd3}};
        b_rst = 1'b1; b_lock = 1'b1; b_soft = 1'b0; b_kick = 1'b0;
        step(); step();
        b_rst = 1'b0;
        edge_cnt = 0;
        foreach (v[i]) begin
            run_to(int'(v[i].e));
            vectors++;
            if ({b_dom, b_rdy, b_cause} !== {v[i].dom, v[i].rdy, v[i].cause}) begin
                miscompares++;
                $display("FAIL wdog_expire@%0d: got dom=%b rdy=%b cause=%0d want dom=%b rdy=%b cause=%0d",
                         edge_cnt, b_dom, b_rdy, b_cause, v[i].dom, v[i].rdy, v[i].cause);
            end
        end
        for (int k = 1; k <= 20; k++) begin
            run_to(2570 + 500 * k - 1);
            b_kick = 1'b1;
            step();
            b_kick = 1'b0;
            vectors++;
            if ({b_dom, b_rdy, b_cause} !== {3'b000, 1'b1, 2'd3}) begin
                miscompares++;
                $display("FAIL wdog_kick@%0d: got dom=%b rdy=%b cause=%0d want dom=000 rdy=1 cause=3",
                         edge_cnt, b_dom, b_rdy, b_cause);
            end
        end
        foreach (w[i]) begin
            run_to(int'(w[i].e));
            vectors++;
            if ({b_dom, b_rdy, b_cause} !== {w[i].dom, w[i].rdy, w[i].cause}) begin
                miscompares++;
                $display("FAIL wdog_after_kicks@%0d: got dom=%b rdy=%b cause=%0d want dom=%b rdy=%b cause=%0d",
                         edge_cnt, b_dom, b_rdy, b_cause, w[i].dom, w[i].rdy, w[i].cause);
            end
        end
    endtask

    initial begin
        a_rst = 1'b1; a_lock = 1'b1; a_soft = 1'b0; a_kick = 1'b0;
        b_rst = 1'b1; b_lock = 1'b1; b_soft = 1'b0; b_kick = 1'b0;
        test_reset();
        test_por_sequence();
        test_lock_loss();
        test_soft_pulse();
        test_sys_rst_mid_release();
        test_late_lock();
        test_soft_held();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
